// File: rtl/adder_result_checker_if.sv
// adder_result_checker_if
//   Stimulus/response bus seen by the adder result checker: the operand pair
//   as presented to the adder under test, plus the adder's sum.
//   Parameter: WIDTH - operand width (sum is WIDTH+1 bits).
//   Signals:   in_valid - operands valid this cycle
//              num1     - operand A
//              num2     - operand B
//              sum      - adder result, valid LAT cycles after its operands
//   Modports:  master - drives the bus (stimulus side)
//              slave  - observes the bus (checker side)
interface adder_result_checker_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [WIDTH:0]   sum;

    modport master (output in_valid, output num1, output num2, output sum);
    modport slave  (input  in_valid, input  num1, input  num2, input  sum);
endinterface

// File: rtl/adder_result_checker.sv
// adder_result_checker
//   Response checker for WIDTH-bit adders. Delays the operands by the adder
//   latency, compares the full WIDTH+1-bit golden sum (carry included) with
//   the adder's sum, counts vectors and mismatches, captures the first failing
//   vector and raises done after NUM_VECTORS vectors.
//   Optional feature macro: CHECKER_HALT_ON_FAIL_EN - when defined, the first
//   mismatch ends the run (done=1 on the same edge that sets fail).
//   Ports:
//     clk       - clock, rising edge
//     reset     - synchronous active-high reset (priority over clear)
//     clear     - synchronous soft restart (priority over bus.in_valid)
//     bus       - operand/sum bus (slave modport)
//     mismatch  - one-cycle pulse per failing vector
//     vec_count - vectors checked
//     err_count - mismatches seen, saturating
//     fail      - sticky, at least one mismatch
//     done      - NUM_VECTORS vectors checked, held
//     ff_num1/ff_num2/ff_sum - first failing vector
module adder_result_checker #(
    parameter int WIDTH       = 8,
    parameter int LAT         = 0,
    parameter int NUM_VECTORS = 256,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    adder_result_checker_if.slave    bus,
    output logic                     mismatch,
    output logic [CNT_W-1:0]         vec_count,
    output logic [CNT_W-1:0]         err_count,
    output logic                     fail,
    output logic                     done,
    output logic [WIDTH-1:0]         ff_num1,
    output logic [WIDTH-1:0]         ff_num2,
    output logic [WIDTH:0]           ff_sum
);

    localparam logic [CNT_W:0] NUM_V = (CNT_W+1)'(NUM_VECTORS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t state;

    logic             al_valid;
    logic [WIDTH-1:0] al_num1;
    logic [WIDTH-1:0] al_num2;

    // Operand alignment: only the valid bits are flushed by reset/clear; the
    // data stages are don't-care while their valid is low.
    generate
        if (LAT == 0) begin : g_wire
            assign al_valid = bus.in_valid;
            assign al_num1  = bus.num1;
            assign al_num2  = bus.num2;
        end else begin : g_pipe
            logic [LAT-1:0]   v_sr;
            logic [WIDTH-1:0] a_sr [LAT];
            logic [WIDTH-1:0] b_sr [LAT];

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    v_sr <= '0;
                end else begin
                    v_sr[0] <= bus.in_valid;
                    for (int unsigned i = 1; i < LAT; i++) begin
                        v_sr[i] <= v_sr[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                a_sr[0] <= bus.num1;
                b_sr[0] <= bus.num2;
                for (int unsigned i = 1; i < LAT; i++) begin
                    a_sr[i] <= a_sr[i-1];
                    b_sr[i] <= b_sr[i-1];
                end
            end

            assign al_valid = v_sr[LAT-1];
            assign al_num1  = a_sr[LAT-1];
            assign al_num2  = b_sr[LAT-1];
        end
    endgenerate

    logic [WIDTH:0] golden;
    logic           is_bad;
    logic [CNT_W:0] vec_next;

    always_comb begin
        golden   = {1'b0, al_num1} + {1'b0, al_num2};
        is_bad   = (golden != bus.sum);
        // one bit wider so the done compare never aliases on wrap
        vec_next = {1'b0, vec_count} + (CNT_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state     <= ST_IDLE;
            mismatch  <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
            fail      <= 1'b0;
            done      <= 1'b0;
            ff_num1   <= '0;
            ff_num2   <= '0;
            ff_sum    <= '0;
        end else begin
            mismatch <= 1'b0;
            // IDLE and CHECK both score an aligned vector; IDLE just marks
            // that nothing has been seen yet.
            if (state != ST_DONE && al_valid) begin
                state     <= ST_CHECK;
                vec_count <= vec_next[CNT_W-1:0];
                if (is_bad) begin
                    mismatch <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                    if (!fail) begin
                        fail    <= 1'b1;
                        ff_num1 <= al_num1;
                        ff_num2 <= al_num2;
                        ff_sum  <= bus.sum;
                    end
`ifdef CHECKER_HALT_ON_FAIL_EN
                    state <= ST_DONE;
                    done  <= 1'b1;
`endif
                end
                if (vec_next == NUM_V) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker
//   Six checker instances with different LAT/NUM_VECTORS/CNT_W, each fed from
//   a per-cycle directed stimulus table. A cycle-indexed reference model
//   derives expected outputs from the operand/sum history; final hand-computed
//   values pin the model.
module tb_adder_result_checker;

    localparam int ND = 6;
    localparam int NC = 40;
    localparam int LATS [ND] = '{0, 2, 0, 1, 0, 3};
    localparam int NVS  [ND] = '{4, 4, 3, 8, 6, 6};
    localparam int CWS  [ND] = '{16, 16, 16, 16, 2, 3};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       clr [ND];
    logic       dv  [ND];
    logic [7:0] da  [ND];
    logic [7:0] db  [ND];
    logic [8:0] ds  [ND];

    logic       tv [ND][NC];
    logic [7:0] ta [ND][NC];
    logic [7:0] tb [ND][NC];
    logic [8:0] ts [ND][NC];
    logic       tc [ND][NC];

    logic        o_mm   [ND];
    logic        o_fail [ND];
    logic        o_done [ND];
    logic [15:0] o_vec  [ND];
    logic [15:0] o_err  [ND];
    logic [7:0]  o_f1   [ND];
    logic [7:0]  o_f2   [ND];
    logic [8:0]  o_fs   [ND];
    logic [1:0]  vc4, ec4;
    logic [2:0]  vc5, ec5;
    assign o_vec[4] = {14'b0, vc4};
    assign o_err[4] = {14'b0, ec4};
    assign o_vec[5] = {13'b0, vc5};
    assign o_err[5] = {13'b0, ec5};

    adder_result_checker_if #(.WIDTH(8)) if0 ();
    adder_result_checker_if #(.WIDTH(8)) if1 ();
    adder_result_checker_if #(.WIDTH(8)) if2 ();
    adder_result_checker_if #(.WIDTH(8)) if3 ();
    adder_result_checker_if #(.WIDTH(8)) if4 ();
    adder_result_checker_if #(.WIDTH(8)) if5 ();
    assign if0.in_valid = dv[0]; assign if0.num1 = da[0]; assign if0.num2 = db[0]; assign if0.sum = ds[0];
    assign if1.in_valid = dv[1]; assign if1.num1 = da[1]; assign if1.num2 = db[1]; assign if1.sum = ds[1];
    assign if2.in_valid = dv[2]; assign if2.num1 = da[2]; assign if2.num2 = db[2]; assign if2.sum = ds[2];
    assign if3.in_valid = dv[3]; assign if3.num1 = da[3]; assign if3.num2 = db[3]; assign if3.sum = ds[3];
    assign if4.in_valid = dv[4]; assign if4.num1 = da[4]; assign if4.num2 = db[4]; assign if4.sum = ds[4];
    assign if5.in_valid = dv[5]; assign if5.num1 = da[5]; assign if5.num2 = db[5]; assign if5.sum = ds[5];

    adder_result_checker #(.WIDTH(8), .LAT(0), .NUM_VECTORS(4), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .clear(clr[0]), .bus(if0.slave),
        .mismatch(o_mm[0]), .vec_count(o_vec[0]), .err_count(o_err[0]), .fail(o_fail[0]),
        .done(o_done[0]), .ff_num1(o_f1[0]), .ff_num2(o_f2[0]), .ff_sum(o_fs[0]));
    adder_result_checker #(.WIDTH(8), .LAT(2), .NUM_VECTORS(4), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .clear(clr[1]), .bus(if1.slave),
        .mismatch(o_mm[1]), .vec_count(o_vec[1]), .err_count(o_err[1]), .fail(o_fail[1]),
        .done(o_done[1]), .ff_num1(o_f1[1]), .ff_num2(o_f2[1]), .ff_sum(o_fs[1]));
    adder_result_checker #(.WIDTH(8), .LAT(0), .NUM_VECTORS(3), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset), .clear(clr[2]), .bus(if2.slave),
        .mismatch(o_mm[2]), .vec_count(o_vec[2]), .err_count(o_err[2]), .fail(o_fail[2]),
        .done(o_done[2]), .ff_num1(o_f1[2]), .ff_num2(o_f2[2]), .ff_sum(o_fs[2]));
    adder_result_checker #(.WIDTH(8), .LAT(1), .NUM_VECTORS(8), .CNT_W(16)) u3 (
        .clk(clk), .reset(reset), .clear(clr[3]), .bus(if3.slave),
        .mismatch(o_mm[3]), .vec_count(o_vec[3]), .err_count(o_err[3]), .fail(o_fail[3]),
        .done(o_done[3]), .ff_num1(o_f1[3]), .ff_num2(o_f2[3]), .ff_sum(o_fs[3]));
    adder_result_checker #(.WIDTH(8), .LAT(0), .NUM_VECTORS(6), .CNT_W(2)) u4 (
        .clk(clk), .reset(reset), .clear(clr[4]), .bus(if4.slave),
        .mismatch(o_mm[4]), .vec_count(vc4), .err_count(ec4), .fail(o_fail[4]),
        .done(o_done[4]), .ff_num1(o_f1[4]), .ff_num2(o_f2[4]), .ff_sum(o_fs[4]));
    adder_result_checker #(.WIDTH(8), .LAT(3), .NUM_VECTORS(6), .CNT_W(3)) u5 (
        .clk(clk), .reset(reset), .clear(clr[5]), .bus(if5.slave),
        .mismatch(o_mm[5]), .vec_count(vc5), .err_count(ec5), .fail(o_fail[5]),
        .done(o_done[5]), .ff_num1(o_f1[5]), .ff_num2(o_f2[5]), .ff_sum(o_fs[5]));

    // reference model state (vector count kept unwrapped)
    int m_vec [ND], m_err [ND], m_f1 [ND], m_f2 [ND], m_fs [ND];
    bit m_mm [ND], m_fail [ND], m_done [ND];

    int checks = 0;
    int errors = 0;
    int cyc    = -1;

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    function automatic void model_reset(input int d);
        m_vec[d] = 0; m_err[d] = 0; m_f1[d] = 0; m_f2[d] = 0; m_fs[d] = 0;
        m_mm[d] = 0; m_fail[d] = 0; m_done[d] = 0;
    endfunction

    // Vector entered at cycle k is scored at cycle k+LAT with that cycle's
    // sum, unless a clear occurred anywhere in cycles k..k+LAT.
    function automatic void model_step(input int d, input int c);
        int k;
        int expv;
        m_mm[d] = 0;
        if (tc[d][c]) begin
            model_reset(d);
            return;
        end
        if (m_done[d]) return;
        k = c - LATS[d];
        if (k < 0) return;
        if (!tv[d][k]) return;
        for (int j = k; j <= c; j++) if (tc[d][j]) return;
        m_vec[d]++;
        expv = int'(ta[d][k]) + int'(tb[d][k]);
        if (int'(ts[d][c]) != expv) begin
            m_mm[d] = 1;
            if (m_err[d] < (1 << CWS[d]) - 1) m_err[d]++;
            if (!m_fail[d]) begin
                m_fail[d] = 1;
                m_f1[d] = int'(ta[d][k]);
                m_f2[d] = int'(tb[d][k]);
                m_fs[d] = int'(ts[d][c]);
            end
`ifdef CHECKER_HALT_ON_FAIL_EN
            m_done[d] = 1;
`endif
        end
        if (m_vec[d] == NVS[d]) m_done[d] = 1;
    endfunction

    task automatic compare_all();
        for (int d = 0; d < ND; d++) begin
            chk("mismatch",  d, int'(o_mm[d]),   int'(m_mm[d]));
            chk("vec_count", d, int'(o_vec[d]),  m_vec[d] % (1 << CWS[d]));
            chk("err_count", d, int'(o_err[d]),  m_err[d]);
            chk("fail",      d, int'(o_fail[d]), int'(m_fail[d]));
            chk("done",      d, int'(o_done[d]), int'(m_done[d]));
            chk("ff_num1",   d, int'(o_f1[d]),   m_f1[d]);
            chk("ff_num2",   d, int'(o_f2[d]),   m_f2[d]);
            chk("ff_sum",    d, int'(o_fs[d]),   m_fs[d]);
        end
    endtask

    task automatic add(input int d, input int c, input int a, input int b, input int s, input int off);
        tv[d][c] = 1'b1;
        ta[d][c] = 8'(a);
        tb[d][c] = 8'(b);
        ts[d][c+off] = 9'(s);
    endtask

    task automatic final_pin(input int d, input int vec, input int err, input int fl, input int dn,
                             input int f1, input int f2, input int fs);
        chk("pin_vec",  d, int'(o_vec[d]),  vec);
        chk("pin_err",  d, int'(o_err[d]),  err);
        chk("pin_fail", d, int'(o_fail[d]), fl);
        chk("pin_done", d, int'(o_done[d]), dn);
        chk("pin_ff1",  d, int'(o_f1[d]),   f1);
        chk("pin_ff2",  d, int'(o_f2[d]),   f2);
        chk("pin_ffs",  d, int'(o_fs[d]),   fs);
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < NC; c++) begin
                tv[d][c] = 1'b0; ta[d][c] = '0; tb[d][c] = '0;
                ts[d][c] = 9'h1AB; tc[d][c] = 1'b0;
            end
            model_reset(d);
            dv[d] = 1'b0; da[d] = '0; db[d] = '0; ds[d] = '0; clr[d] = 1'b0;
        end
        // dut0: all good, gap at cycle 4, wrong vector after done is ignored
        add(0, 2, 1, 2, 3, 0);     add(0, 3, 255, 1, 256, 0);
        add(0, 5, 128, 128, 256, 0); add(0, 6, 0, 0, 0, 0);
        add(0, 8, 5, 5, 0, 0);
        // dut1: LAT=2 correct timing, clear, then sums with zero-latency timing
        add(1, 2, 1, 2, 3, 2);     add(1, 3, 255, 1, 256, 2);
        add(1, 4, 128, 128, 256, 2); add(1, 5, 0, 0, 0, 2);
        tc[1][9] = 1'b1;
        add(1, 11, 1, 2, 3, 0);    add(1, 12, 255, 1, 256, 0);
        add(1, 13, 128, 128, 256, 0); add(1, 14, 0, 0, 0, 0);
        ts[1][15] = 9'd0; ts[1][16] = 9'd0;
        // dut2: dropped carry, then off-by-one
        add(2, 2, 10, 5, 15, 0);   add(2, 3, 200, 100, 44, 0); add(2, 4, 7, 7, 15, 0);
        // dut3: two errors, vector in flight, clear coincident with a vector
        add(3, 2, 1, 1, 2, 1);     add(3, 3, 2, 2, 5, 1);
        add(3, 4, 3, 3, 7, 1);     add(3, 5, 4, 4, 8, 1);
        add(3, 6, 9, 9, 18, 1);    tc[3][6] = 1'b1;
        add(3, 8, 6, 6, 12, 1);    add(3, 9, 1, 2, 4, 1);
        // dut4: five wrong sums into a 2-bit error counter
        for (int i = 0; i < 5; i++) add(4, 2 + i, i + 1, 1, 0, 0);
        // dut5: six wrong sums, LAT=3
        for (int i = 0; i < 6; i++) add(5, 2 + i, i + 1, i + 1, 1, 3);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compare_all();

        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            reset = 1'b0;
            for (int d = 0; d < ND; d++) begin
                dv[d] = tv[d][c]; da[d] = ta[d][c]; db[d] = tb[d][c];
                ds[d] = ts[d][c]; clr[d] = tc[d][c];
            end
            @(posedge clk);
            for (int d = 0; d < ND; d++) model_step(d, c);
            #1;
            cyc = c;
            compare_all();
            if (c == 6) begin
                chk("done_on_4th", 0, int'(o_done[0]), 1);
                chk("clr_vec",  3, int'(o_vec[3]),  0);
                chk("clr_err",  3, int'(o_err[3]),  0);
                chk("clr_fail", 3, int'(o_fail[3]), 0);
            end
        end

        cyc = NC;
        final_pin(0, 4, 0, 0, 1, 0, 0, 0);
`ifdef CHECKER_HALT_ON_FAIL_EN
        final_pin(1, 1, 1, 1, 1, 1, 2, 256);
        final_pin(2, 2, 1, 1, 1, 200, 100, 44);
        final_pin(3, 2, 1, 1, 1, 1, 2, 4);
        final_pin(4, 1, 1, 1, 1, 1, 1, 0);
        final_pin(5, 1, 1, 1, 1, 1, 1, 1);
`else
        final_pin(1, 4, 3, 1, 1, 1, 2, 256);
        final_pin(2, 3, 2, 1, 1, 200, 100, 44);
        final_pin(3, 2, 1, 1, 0, 1, 2, 4);
        chk("sat_err",  4, int'(o_err[4]),  3);
        chk("sat_fail", 4, int'(o_fail[4]), 1);
        chk("sat_done", 4, int'(o_done[4]), 0);
        final_pin(5, 6, 6, 1, 1, 1, 1, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
